dmem_resp: RTL

Data-memory responder: the slave end of the execution unit's load/store port (`mem_r_addr`, `mem_r`, `mem_w_addr`, `mem_w`, `mem_w_en`). It owns a word-organised RAM window and services one request at a time through a valid/ready handshake, with a fixed, configurable response latency. It sits between the core's execute stage and the simulated data memory, and replaces the zero-latency combinational memory path.

---
 rtl/dmem_resp.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: single-request valid/ready data-memory responder with a fixed response latency.
// Define DMEM_BYTE_STRB_EN to add the mem_w_strb port and byte-lane write enables.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif
`ifndef BASE_ADDR
`define BASE_ADDR 32'h0000_1000
`endif

module dmem_resp #(
  parameter int unsigned           DEPTH_LOG2 = 10,
  parameter int unsigned           LATENCY    = 2,
  parameter logic [`ISA_WIDTH-1:0] BASE       = `BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [`ISA_WIDTH-1:0] mem_r_addr,
  input  logic [`ISA_WIDTH-1:0] mem_w_addr,
  input  logic [`ISA_WIDTH-1:0] mem_w,
  input  logic                  mem_w_en,
`ifdef DMEM_BYTE_STRB_EN
  input  logic [3:0]            mem_w_strb,
`endif
  output logic                  resp_valid,
  output logic [`ISA_WIDTH-1:0] mem_r,
  output logic                  resp_err
);
  localparam int W     = `ISA_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       enter_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = !rst && (state_d == RESP);
  assign req_ready  = !rst && (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // Captured request; datapath only, so no reset is needed.
  logic [W-1:0] r_addr_q, w_addr_q, w_data_q;
  logic         w_en_q;
  logic [3:0]   strb_in, strb_cap;

`ifdef DMEM_BYTE_STRB_EN
  logic [3:0] strb_q;
  assign strb_in  = mem_w_strb;
  assign strb_cap = strb_q;
  always_ff @(posedge clk) begin
    if (accept && !rst) strb_q <= mem_w_strb;
  end
`else
  assign strb_in  = 4'hF;
  assign strb_cap = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      r_addr_q <= mem_r_addr;
      w_addr_q <= mem_w_addr;
      w_data_q <= mem_w;
      w_en_q   <= mem_w_en;
    end
  end

  // With LATENCY==1 the accept edge is also the RESP entry edge, so decode the live inputs.
  logic         from_inputs;
  logic [W-1:0] r_addr, w_addr, w_data;
  logic         w_en;
  logic [3:0]   strb;
  logic [W:0]   r_off, w_off;
  logic         r_ok, w_ok, w_any, do_write;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx;
  logic         unused_lsb;

  assign from_inputs = (state_q == IDLE);
  assign r_addr      = from_inputs ? mem_r_addr : r_addr_q;
  assign w_addr      = from_inputs ? mem_w_addr : w_addr_q;
  assign w_data      = from_inputs ? mem_w      : w_data_q;
  assign w_en        = from_inputs ? mem_w_en   : w_en_q;
  assign strb        = from_inputs ? strb_in    : strb_cap;

  // Extra top bit catches addresses below BASE as a borrow.
  assign r_off = {1'b0, r_addr} - {1'b0, BASE};
  assign w_off = {1'b0, w_addr} - {1'b0, BASE};
  assign r_ok  = ~r_off[W] & ~|r_off[W-1:DEPTH_LOG2+2];
  assign w_ok  = ~w_off[W] & ~|w_off[W-1:DEPTH_LOG2+2];
  assign r_idx = r_off[DEPTH_LOG2+1:2];
  assign w_idx = w_off[DEPTH_LOG2+1:2];
  assign unused_lsb = ^{r_off[1:0], w_off[1:0]};

  assign w_any    = w_en & |strb;
  assign do_write = enter_resp & w_any & w_ok;

  logic [W-1:0] rd_word_q;

  // One RAM per byte lane; the registered read sees the pre-write contents.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram [DEPTH];
    always_ff @(posedge clk) begin
      if (enter_resp) rd_word_q[8*gi +: 8] <= ram[r_idx];
      if (do_write && strb[gi]) ram[w_idx] <= w_data[8*gi +: 8];
    end
  end

  logic rd_ok_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rd_ok_q <= r_ok;
      err_q   <= ~r_ok | (w_any & ~w_ok);
    end
  end

  assign mem_r    = rd_ok_q ? rd_word_q : '0;
  assign resp_err = err_q;

endmodule
